imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter ADDRESS_BITS, default 16, byte-address width of fetch requests and write port.
REQ-002 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 Parameter INDEX_BITS, default 8, log2 of word count in storage array (256 words).
REQ-004 Parameter DEPTH, default 4, max outstanding requests (in-flight plus buffered); SHALL be >= 3.
REQ-005 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  1  fetch side presents a PC.
REQ-008 req_ready  output  1  responder can accept a request this cycle.
REQ-009 req_address  input  ADDRESS_BITS  byte address (PC) of requested instruction.
REQ-010 flush  input  1  redirect; discards all older requests and responses.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  fetch side consumes the response.
REQ-013 resp_data  output  DATA_WIDTH  instruction word.
REQ-014 resp_address  output  ADDRESS_BITS  request address echoed with the response.
REQ-015 resp_error  output  1  misaligned or out-of-range request.
REQ-016 write_enable  input  1  loader writes one word.
REQ-017 write_address  input  ADDRESS_BITS  byte address of written word.
REQ-018 write_data  input  DATA_WIDTH  word to store.

Function
REQ-019 Request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-020 Word index SHALL be address[INDEX_BITS+1:2]; a write SHALL be ignored if address[1:0]!=0 or any bit above INDEX_BITS+1 is set.
REQ-021 Request with address[1:0]!=0 or any bit above INDEX_BITS+1 set SHALL produce resp_error=1, resp_data=0; otherwise resp_error=0.
REQ-022 Array SHALL be read in the acceptance cycle; read-before-write: a same-cycle write to the same word SHALL NOT be visible to that request, and SHALL be visible to requests accepted one or more cycles later.
REQ-023 Fixed two-stage pipeline: request accepted at edge N SHALL have resp_valid high after edge N+2 when the response buffer is empty and no flush occurs.
REQ-024 Pipeline output SHALL enter a FIFO response buffer of DEPTH entries; responses SHALL be delivered in acceptance order.
REQ-025 resp_valid/resp_data/resp_address/resp_error SHALL come from the FIFO head and SHALL remain stable while resp_valid && !resp_ready.
REQ-026 Response popped on an edge where resp_valid && resp_ready.
REQ-027 outstanding = in-flight stages + FIFO count; req_ready SHALL be combinational: (outstanding < DEPTH) || (resp_valid && resp_ready); req_ready SHALL NOT depend on req_valid.
REQ-028 Simultaneous pop and pipeline push to a full-1 or full FIFO SHALL not lose or duplicate entries.
REQ-029 flush at edge N SHALL invalidate both pipeline stages and empty the FIFO; resp_valid SHALL be 0 after edge N.
REQ-030 A request accepted in the same cycle as flush SHALL survive and respond after edge N+2; req_ready SHALL be 1 during flush.
REQ-031 A resp_ready handshake in a flush cycle SHALL count as consumed; no duplicate.

Reset
REQ-032 While reset high: req_ready=0 not required; req_ready SHALL be 1 after deassert; resp_valid=0, resp_data=0, resp_address=0, resp_error=0, pipeline valids=0, FIFO empty, outstanding=0.
REQ-033 Storage array SHALL NOT be cleared by reset; reset mid-operation SHALL drop all in-flight and buffered responses immediately.

Verification
REQ-034 Load word 0x00000013 at 0x0000 and 0x00A00093 at 0x0004; request 0x0000 at edge N -> resp_valid after edge N+2, resp_data=0x00000013, resp_address=0x0000, resp_error=0.
REQ-035 Hold resp_ready=0, issue back-to-back requests 0x0000,0x0004,0x0008,0x000C -> req_ready=0 after 4 accepted; release resp_ready -> four in-order responses, none lost.
REQ-036 Request 0x0002 -> resp_error=1, resp_data=0; request 0x0400 (INDEX_BITS=8) -> resp_error=1.
REQ-037 Two requests in flight, assert flush with new request 0x0010 -> only 0x0010 response appears, two edges later.
REQ-038 Write 0xDEADBEEF to 0x0008 in same cycle as request 0x0008 -> old word returned; next request 0x0008 -> 0xDEADBEEF.
REQ-039 Assert reset with three responses buffered -> resp_valid=0 immediately; after release, previously loaded words still readable.

Source files
------------

// File: rtl/imem_if.sv
// Fetch-side handshake bundle for the instruction memory responder:
// request channel, flush/redirect and response channel.
interface imem_if #(
    parameter int ADDRESS_BITS = 16,
    parameter int DATA_WIDTH   = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic [ADDRESS_BITS-1:0] req_address;
    logic                    flush;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [DATA_WIDTH-1:0]   resp_data;
    logic [ADDRESS_BITS-1:0] resp_address;
    logic                    resp_error;

    modport master (
        output req_valid, req_address, flush, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_address, resp_error
    );

    modport slave (
        input  req_valid, req_address, flush, resp_ready,
        output req_ready, resp_valid, resp_data, resp_address, resp_error
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: word array read in the acceptance cycle, a fixed
// two-stage pipeline, and an in-order response FIFO with flush and backpressure.
module imem_responder #(
    parameter int ADDRESS_BITS = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int INDEX_BITS   = 8,
    parameter int DEPTH        = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    imem_if.slave                   bus,
    input  logic                    write_enable,
    input  logic [ADDRESS_BITS-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]   write_data
);
    localparam int WORDS = 1 << INDEX_BITS;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = CNT_W + 2;

    // Misaligned, or beyond the word array: upper address bits must all be zero.
    function automatic logic addr_bad(input logic [ADDRESS_BITS-1:0] a);
        logic [ADDRESS_BITS-1:0] upper;
        upper = a >> (INDEX_BITS + 2);
        return (a[1:0] != 2'b00) || (upper != '0);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [DATA_WIDTH-1:0]   mem [WORDS];
    logic [INDEX_BITS-1:0]   rd_index;
    logic [INDEX_BITS-1:0]   wr_index;
    logic                    accept;
    logic                    wr_ok;
    logic                    pop;
    logic                    push;

    logic                    s1_valid_reg;
    logic                    s1_error_reg;
    logic [ADDRESS_BITS-1:0] s1_address_reg;
    logic [DATA_WIDTH-1:0]   s1_word_reg;
    logic                    s2_valid_reg;
    logic                    s2_error_reg;
    logic [ADDRESS_BITS-1:0] s2_address_reg;
    logic [DATA_WIDTH-1:0]   s2_data_reg;

    logic [DATA_WIDTH-1:0]   fifo_data_reg    [DEPTH];
    logic [ADDRESS_BITS-1:0] fifo_address_reg [DEPTH];
    logic                    fifo_error_reg   [DEPTH];
    logic [DEPTH-1:0]        slot_we;
    logic [PTR_W-1:0]        head_reg, head_next;
    logic [PTR_W-1:0]        tail_reg, tail_next;
    logic [CNT_W-1:0]        count_reg, count_next;
    logic [OUT_W-1:0]        outstanding;

    assign rd_index = bus.req_address[INDEX_BITS+1:2];
    assign wr_index = write_address[INDEX_BITS+1:2];
    assign wr_ok    = write_enable && !addr_bad(write_address);
    assign accept   = bus.req_valid && bus.req_ready;
    assign pop      = bus.resp_valid && bus.resp_ready;
    // A flush discards whatever sits in stage 2, so it never reaches the FIFO.
    assign push     = s2_valid_reg && !bus.flush;

    // Everything in flight eventually lands in the FIFO, so bounding the sum
    // by DEPTH guarantees a push always finds a free slot.
    assign outstanding   = OUT_W'(count_reg) + OUT_W'(s1_valid_reg) + OUT_W'(s2_valid_reg);
    assign bus.req_ready = bus.flush || (outstanding < OUT_W'(DEPTH)) || pop;

    assign bus.resp_valid   = (count_reg != '0);
    assign bus.resp_data    = bus.resp_valid ? fifo_data_reg[head_reg]    : '0;
    assign bus.resp_address = bus.resp_valid ? fifo_address_reg[head_reg] : '0;
    assign bus.resp_error   = bus.resp_valid ? fifo_error_reg[head_reg]   : 1'b0;

    // Storage is not reset. Non-blocking write plus read in one block gives
    // read-before-write on a same-cycle collision.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_index] <= write_data;
        end
        if (accept) begin
            s1_word_reg <= mem[rd_index];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_reg   <= 1'b0;
            s1_error_reg   <= 1'b0;
            s1_address_reg <= '0;
            s2_valid_reg   <= 1'b0;
            s2_error_reg   <= 1'b0;
            s2_address_reg <= '0;
            s2_data_reg    <= '0;
        end else begin
            // A request accepted alongside a flush is the new stream and survives.
            s1_valid_reg <= accept;
            if (accept) begin
                s1_address_reg <= bus.req_address;
                s1_error_reg   <= addr_bad(bus.req_address);
            end
            s2_valid_reg   <= s1_valid_reg && !bus.flush;
            s2_address_reg <= s1_address_reg;
            s2_error_reg   <= s1_error_reg;
            s2_data_reg    <= s1_error_reg ? '0 : s1_word_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
            assign slot_we[gi] = push && (tail_reg == PTR_W'(gi));
        end
    endgenerate

    // Slot contents need no reset: outputs are gated by the occupancy count.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_we[i]) begin
                fifo_data_reg[i]    <= s2_data_reg;
                fifo_address_reg[i] <= s2_address_reg;
                fifo_error_reg[i]   <= s2_error_reg;
            end
        end
    end

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (bus.flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (push) begin
                tail_next = ptr_inc(tail_reg);
            end
            if (pop) begin
                head_next = ptr_inc(head_reg);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: each task drives one scenario and checks
// its responses against hand-computed values.
module tb_imem_responder;
    logic        clock;
    logic        reset;
    logic        write_enable;
    logic [15:0] write_address;
    logic [31:0] write_data;
    int          checks;
    int          errors;

    imem_if #(.ADDRESS_BITS(16), .DATA_WIDTH(32)) bus ();

    imem_responder #(
        .ADDRESS_BITS(16), .DATA_WIDTH(32), .INDEX_BITS(8), .DEPTH(4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .write_enable (write_enable),
        .write_address(write_address),
        .write_data   (write_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [15:0] a, input logic [31:0] d);
        write_enable  = 1'b1;
        write_address = a;
        write_data    = d;
        step();
        write_enable  = 1'b0;
        $display("write addr=%h data=%h", a, d);
    endtask

    task automatic do_req(input logic [15:0] a);
        bus.req_valid   = 1'b1;
        bus.req_address = a;
        step();
        bus.req_valid   = 1'b0;
    endtask

    task automatic wait_resp(output bit got);
        for (int i = 0; i < 20 && !bus.resp_valid; i++) step();
        got = bus.resp_valid;
    endtask

    task automatic pop_resp();
        $display("resp addr=%h data=%h err=%0b", bus.resp_address, bus.resp_data, bus.resp_error);
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.resp_valid); end
        checks++; if (bus.resp_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.resp_data); end
        checks++; if (bus.resp_address !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.resp_address); end
        checks++; if (bus.resp_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.resp_error); end
        reset = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready); end
        step();
    endtask

    task automatic test_basic();
        bus.req_valid   = 1'b1;
        bus.req_address = 16'h0000;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b expected 1", bus.req_ready); end
        step();
        bus.req_valid = 1'b0;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1: resp_valid %b expected 0", bus.resp_valid); end
        step();
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL basic_lat2: resp_valid %b expected 0", bus.resp_valid); end
        step();
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL basic_lat3: resp_valid %b expected 1", bus.resp_valid); end
        checks++; if (bus.resp_data !== 32'h00000013) begin errors++; $display("FAIL basic_data: got %h expected 00000013", bus.resp_data); end
        checks++; if (bus.resp_address !== 16'h0000) begin errors++; $display("FAIL basic_addr: got %h expected 0000", bus.resp_address); end
        checks++; if (bus.resp_error !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", bus.resp_error); end
        pop_resp();
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: resp_valid %b expected 0", bus.resp_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_data [4];
        exp_data[0] = 32'h00000013; exp_data[1] = 32'h00A00093;
        exp_data[2] = 32'h11111111; exp_data[3] = 32'h22222222;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_valid   = 1'b1;
            bus.req_address = 16'(4 * i);
            #1;
            checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_accept%0d: req_ready %b expected 1", i, bus.req_ready); end
            step();
        end
        bus.req_address = 16'h0010;
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_full: req_ready %b expected 0", bus.req_ready); end
        bus.req_valid = 1'b0;
        step();
        step();
        checks++; if (bus.resp_data !== 32'h00000013) begin errors++; $display("FAIL bp_stable: got %h expected 00000013", bus.resp_data); end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_full2: req_ready %b expected 0", bus.req_ready); end
        bus.resp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_pop_ready: req_ready %b expected 1", bus.req_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d: got %b expected 1", i, bus.resp_valid); end
            checks++; if (bus.resp_address !== 16'(4 * i)) begin errors++; $display("FAIL bp_addr%0d: got %h expected %h", i, bus.resp_address, 16'(4 * i)); end
            checks++; if (bus.resp_data !== exp_data[i]) begin errors++; $display("FAIL bp_data%0d: got %h expected %h", i, bus.resp_data, exp_data[i]); end
            $display("resp addr=%h data=%h err=%0b", bus.resp_address, bus.resp_data, bus.resp_error);
            step();
        end
        bus.resp_ready = 1'b0;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: resp_valid %b expected 0", bus.resp_valid); end
    endtask

    task automatic test_error();
        logic [15:0] addrs [5];
        logic [31:0] exp_data [5];
        logic        exp_err [5];
        bit          got;
        addrs[0] = 16'h0002; exp_data[0] = 32'h0;        exp_err[0] = 1'b1;
        addrs[1] = 16'h0400; exp_data[1] = 32'h0;        exp_err[1] = 1'b1;
        addrs[2] = 16'h03FC; exp_data[2] = 32'h44444444; exp_err[2] = 1'b0;
        addrs[3] = 16'h0000; exp_data[3] = 32'h00000013; exp_err[3] = 1'b0;
        addrs[4] = 16'h0004; exp_data[4] = 32'h00A00093; exp_err[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_req(addrs[i]);
            wait_resp(got);
            checks++; if (!got) begin errors++; $display("FAIL err_timeout%0d: resp_valid 0 expected 1", i); end
            checks++; if (bus.resp_error !== exp_err[i]) begin errors++; $display("FAIL err_flag%0d: got %b expected %b", i, bus.resp_error, exp_err[i]); end
            checks++; if (bus.resp_data !== exp_data[i]) begin errors++; $display("FAIL err_data%0d: got %h expected %h", i, bus.resp_data, exp_data[i]); end
            checks++; if (bus.resp_address !== addrs[i]) begin errors++; $display("FAIL err_addr%0d: got %h expected %h", i, bus.resp_address, addrs[i]); end
            pop_resp();
        end
    endtask

    task automatic test_flush();
        do_req(16'h0000);
        do_req(16'h0004);
        bus.flush       = 1'b1;
        bus.req_valid   = 1'b1;
        bus.req_address = 16'h0010;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", bus.req_ready); end
        step();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL flush_n0: resp_valid %b expected 0", bus.resp_valid); end
        step();
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL flush_n1: resp_valid %b expected 0", bus.resp_valid); end
        step();
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL flush_n2: resp_valid %b expected 1", bus.resp_valid); end
        checks++; if (bus.resp_address !== 16'h0010) begin errors++; $display("FAIL flush_addr: got %h expected 0010", bus.resp_address); end
        checks++; if (bus.resp_data !== 32'h33333333) begin errors++; $display("FAIL flush_data: got %h expected 33333333", bus.resp_data); end
        pop_resp();
        step();
        step();
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL flush_stale: resp_valid %b expected 0", bus.resp_valid); end
    endtask

    task automatic test_flush_full();
        for (int i = 0; i < 4; i++) do_req(16'(4 * i));
        step();
        step();
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL ffull_pre: req_ready %b expected 0", bus.req_ready); end
        bus.flush       = 1'b1;
        bus.resp_ready  = 1'b1;
        bus.req_valid   = 1'b1;
        bus.req_address = 16'h0004;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL ffull_ready: got %b expected 1", bus.req_ready); end
        step();
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b0;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL ffull_cleared: resp_valid %b expected 0", bus.resp_valid); end
        step();
        step();
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL ffull_n2: resp_valid %b expected 1", bus.resp_valid); end
        checks++; if (bus.resp_address !== 16'h0004) begin errors++; $display("FAIL ffull_addr: got %h expected 0004", bus.resp_address); end
        checks++; if (bus.resp_data !== 32'h00A00093) begin errors++; $display("FAIL ffull_data: got %h expected 00a00093", bus.resp_data); end
        pop_resp();
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL ffull_dup: resp_valid %b expected 0", bus.resp_valid); end
    endtask

    task automatic test_read_before_write();
        bit got;
        write_enable    = 1'b1;
        write_address   = 16'h0008;
        write_data      = 32'hDEADBEEF;
        bus.req_valid   = 1'b1;
        bus.req_address = 16'h0008;
        step();
        write_enable = 1'b0;
        bus.req_valid = 1'b0;
        do_req(16'h0008);
        wait_resp(got);
        checks++; if (!got) begin errors++; $display("FAIL rbw_timeout0: resp_valid 0 expected 1"); end
        checks++; if (bus.resp_data !== 32'h11111111) begin errors++; $display("FAIL rbw_old: got %h expected 11111111", bus.resp_data); end
        pop_resp();
        wait_resp(got);
        checks++; if (!got) begin errors++; $display("FAIL rbw_timeout1: resp_valid 0 expected 1"); end
        checks++; if (bus.resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rbw_new: got %h expected deadbeef", bus.resp_data); end
        pop_resp();
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [8];
        logic [31:0] exp_data [8];
        int sent;
        int got_n;
        addrs = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h03FC, 16'h0000, 16'h0004};
        exp_data = '{32'h00000013, 32'h00A00093, 32'hDEADBEEF, 32'h22222222,
                     32'h33333333, 32'h44444444, 32'h00000013, 32'h00A00093};
        sent  = 0;
        got_n = 0;
        bus.resp_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got_n < 8; cyc++) begin
            if (bus.resp_valid) begin
                checks++; if (bus.resp_address !== addrs[got_n]) begin errors++; $display("FAIL b2b_addr%0d: got %h expected %h", got_n, bus.resp_address, addrs[got_n]); end
                checks++; if (bus.resp_data !== exp_data[got_n]) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", got_n, bus.resp_data, exp_data[got_n]); end
                $display("resp addr=%h data=%h err=%0b", bus.resp_address, bus.resp_data, bus.resp_error);
                got_n++;
            end
            if (sent < 8) begin
                bus.req_valid   = 1'b1;
                bus.req_address = addrs[sent];
                #1;
                checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", sent, bus.req_ready); end
                sent++;
            end else begin
                bus.req_valid = 1'b0;
            end
            step();
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        checks++; if (got_n != 8) begin errors++; $display("FAIL b2b_count: got %0d responses expected 8", got_n); end
    endtask

    task automatic test_reset_midway();
        bit got;
        do_req(16'h0000);
        do_req(16'h0004);
        do_req(16'h0008);
        step();
        step();
        step();
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: resp_valid %b expected 1", bus.resp_valid); end
        reset = 1'b1;
        #1;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", bus.resp_valid); end
        checks++; if (bus.resp_data !== 32'h0) begin errors++; $display("FAIL rst_mid_data: got %h expected 0", bus.resp_data); end
        step();
        reset = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", bus.req_ready); end
        step();
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_empty: resp_valid %b expected 0", bus.resp_valid); end
        do_req(16'h0004);
        wait_resp(got);
        checks++; if (!got) begin errors++; $display("FAIL rst_mid_timeout0: resp_valid 0 expected 1"); end
        checks++; if (bus.resp_data !== 32'h00A00093) begin errors++; $display("FAIL rst_mid_keep0: got %h expected 00a00093", bus.resp_data); end
        pop_resp();
        do_req(16'h0010);
        wait_resp(got);
        checks++; if (!got) begin errors++; $display("FAIL rst_mid_timeout1: resp_valid 0 expected 1"); end
        checks++; if (bus.resp_data !== 32'h33333333) begin errors++; $display("FAIL rst_mid_keep1: got %h expected 33333333", bus.resp_data); end
        pop_resp();
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        write_enable    = 1'b0;
        write_address   = '0;
        write_data      = '0;
        bus.req_valid   = 1'b0;
        bus.req_address = '0;
        bus.flush       = 1'b0;
        bus.resp_ready  = 1'b0;

        test_reset();
        load_word(16'h0000, 32'h00000013);
        load_word(16'h0004, 32'h00A00093);
        load_word(16'h0008, 32'h11111111);
        load_word(16'h000C, 32'h22222222);
        load_word(16'h0010, 32'h33333333);
        load_word(16'h03FC, 32'h44444444);
        load_word(16'h0400, 32'hBAD0BAD0);
        load_word(16'h0006, 32'hBAD1BAD1);

        test_basic();
        test_backpressure();
        test_error();
        test_flush();
        test_flush_full();
        test_read_before_write();
        test_back_to_back();
        test_reset_midway();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
